// File: rtl/reg_bus_master_if.sv
// rtl/reg_bus_master_if.sv - command handshake and register-bus strobes for reg_bus_master
interface reg_bus_master_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [IDX_W-1:0]  cmd_src;
  logic [IDX_W-1:0]  cmd_dst;
  logic [DATA_W-1:0] cmd_imm;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic [IDX_W-1:0]  bus_index;
  logic              bus_rEn;
  logic              bus_wEn;

  modport master (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    output cmd_ready, rd_data, rd_valid, done, err,
    output bus_index, bus_rEn, bus_wEn
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm,
    input  cmd_ready, rd_data, rd_valid, done, err,
    input  bus_index, bus_rEn, bus_wEn
  );

endinterface

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - register-file bus initiator sequencing LDI/MOV/RD strobes
// Optional index range check is enabled by defining REG_BUS_RANGE_CHECK_EN.
module reg_bus_master #(
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 4,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset,
  reg_bus_master_if.master  mif,
  inout  wire  [DATA_W-1:0] bus
);

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LDI = 2'b01,
    OP_MOV = 2'b10,
    OP_RD  = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_RD2, S_TURN, S_WR1, S_WR2, S_WR3, S_DONE, S_ERR
  } state_t;

`ifdef REG_BUS_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

  state_t            state;
  op_t               op_q;
  logic [IDX_W-1:0]  dst_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              ready_q, ren_q, wen_q, drive_q;
  logic              rd_valid_q, done_q, err_q;
  logic              src_bad, dst_bad, idx_bad;

  // Flag a command whose used indices fall outside the implemented register range
  always_comb begin
    src_bad = ({1'b0, mif.cmd_src} >= NUM_REGS_W);
    dst_bad = ({1'b0, mif.cmd_dst} >= NUM_REGS_W);
    idx_bad = 1'b0;
    case (op_t'(mif.cmd_op))
      OP_LDI:  idx_bad = dst_bad;
      OP_MOV:  idx_bad = src_bad | dst_bad;
      OP_RD:   idx_bad = src_bad;
      default: idx_bad = 1'b0;
    endcase
    idx_bad = idx_bad & RANGE_CHK;
  end

  // Command sequencer: state plus every registered output toward the bus and control unit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      dst_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      rd_data_q  <= '0;
      ready_q    <= 1'b1;
      ren_q      <= 1'b0;
      wen_q      <= 1'b0;
      drive_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mif.cmd_valid) begin
            ready_q <= 1'b0;
            op_q    <= op_t'(mif.cmd_op);
            dst_q   <= mif.cmd_dst;
            if (idx_bad) begin
              err_q <= 1'b1;
              state <= S_ERR;
            end else begin
              case (op_t'(mif.cmd_op))
                OP_LDI: begin
                  data_q  <= mif.cmd_imm;
                  idx_q   <= mif.cmd_dst;
                  drive_q <= 1'b1;
                  state   <= S_WR1;
                end
                OP_MOV, OP_RD: begin
                  idx_q <= mif.cmd_src;
                  ren_q <= 1'b1;
                  state <= S_RD1;
                end
                default: begin
                  done_q <= 1'b1;
                  state  <= S_DONE;
                end
              endcase
            end
          end
        end
        S_RD1: state <= S_RD2;
        S_RD2: begin
          // Register still drives the bus during this cycle, so capture its value here
          data_q <= bus;
          ren_q  <= 1'b0;
          if (op_q == OP_RD) begin
            rd_data_q  <= bus;
            rd_valid_q <= 1'b1;
            done_q     <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_TURN;
          end
        end
        S_TURN: begin
          idx_q   <= dst_q;
          drive_q <= 1'b1;
          state   <= S_WR1;
        end
        S_WR1: begin
          wen_q <= 1'b1;
          state <= S_WR2;
        end
        S_WR2: begin
          wen_q <= 1'b0;
          state <= S_WR3;
        end
        S_WR3: begin
          drive_q <= 1'b0;
          done_q  <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE, S_ERR: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          ren_q   <= 1'b0;
          wen_q   <= 1'b0;
          drive_q <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus           = drive_q ? data_q : {DATA_W{1'bz}};
  assign mif.cmd_ready = ready_q;
  assign mif.rd_data   = rd_data_q;
  assign mif.rd_valid  = rd_valid_q;
  assign mif.done      = done_q;
  assign mif.err       = err_q;
  assign mif.bus_index = idx_q;
  assign mif.bus_rEn   = ren_q;
  assign mif.bus_wEn   = wen_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed self-checking bench for reg_bus_master
module tb_reg_bus_master;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_MOV = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  wire [15:0] bus;

  reg_bus_master_if mif ();

  reg_bus_master dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file stand-in: drives while rEn is high, captures on rising wEn
  logic [15:0] regs [0:3];
  assign bus = (mif.bus_rEn && mif.bus_index < 4'd4) ? regs[mif.bus_index[1:0]] : 16'hzzzz;

  // Register contents reset with the bench reset, written on each write strobe
  always @(posedge mif.bus_wEn or posedge reset) begin
    if (reset) begin
      regs[0] <= 16'h0002;
      regs[1] <= 16'h0003;
      regs[2] <= 16'h0000;
      regs[3] <= 16'h0000;
    end else if (mif.bus_index < 4'd4) begin
      regs[mif.bus_index[1:0]] <= bus;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic floated(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  logic        ren_a [1:10];
  logic        flt_a [1:10];
  logic [15:0] bus_a [1:10];
  logic [3:0]  idx_a [1:10];
  int done_k, err_k, done_cnt, err_cnt, rdv_cnt, wen_cnt, strobe_cnt, overlap;
  logic [15:0] rdata, w_bus;
  logic [3:0]  w_idx;

  task automatic do_reset();
    @(negedge clk);
    mif.cmd_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one command, scramble cmd_* after acceptance, and record 10 cycles of bus activity
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                         input logic [15:0] imm);
    int n = 0;
    @(negedge clk);
    while (!mif.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    mif.cmd_op = op; mif.cmd_src = src; mif.cmd_dst = dst; mif.cmd_imm = imm;
    mif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.cmd_valid = 1'b0;
    mif.cmd_op = ~op; mif.cmd_src = ~src; mif.cmd_dst = ~dst; mif.cmd_imm = ~imm;
    done_k = -1; err_k = -1; done_cnt = 0; err_cnt = 0; rdv_cnt = 0;
    wen_cnt = 0; strobe_cnt = 0; overlap = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ren_a[k] = mif.bus_rEn;
      flt_a[k] = floated(bus);
      bus_a[k] = bus;
      idx_a[k] = mif.bus_index;
      if (mif.done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (mif.err) begin err_cnt++; if (err_k < 0) err_k = k; end
      if (mif.rd_valid) begin rdv_cnt++; rdata = mif.rd_data; end
      if (mif.bus_wEn) begin wen_cnt++; w_bus = bus; w_idx = mif.bus_index; end
      if (mif.bus_rEn || mif.bus_wEn) strobe_cnt++;
      if (mif.bus_rEn && mif.bus_wEn) overlap++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, j, n;
    int acc [0:2];
    logic [3:0]  qd [0:2];
    logic [15:0] qi [0:2];

    mif.cmd_valid = 1'b0; mif.cmd_op = OP_NOP;
    mif.cmd_src = '0; mif.cmd_dst = '0; mif.cmd_imm = '0;
    do_reset();
    #1;
    check("rst_ready", 32'(mif.cmd_ready), 1);
    check("rst_ren", 32'(mif.bus_rEn), 0);
    check("rst_wen", 32'(mif.bus_wEn), 0);
    check("rst_index", 32'(mif.bus_index), 0);
    check("rst_rd_data", 32'(mif.rd_data), 0);
    check("rst_pulses", 32'({mif.rd_valid, mif.done, mif.err}), 0);
    check("rst_bus_z", 32'(floated(bus)), 1);

    run_cmd(OP_RD, 4'd0, 4'd0, 16'h0);
    check("rd0_data", 32'(rdata), 32'h0002);
    check("rd0_valid_cnt", rdv_cnt, 1);
    check("rd0_done_k", done_k, 3);
    check("rd0_idx", 32'(idx_a[1]), 0);
    run_cmd(OP_RD, 4'd1, 4'd0, 16'h0);
    check("rd1_data", 32'(rdata), 32'h0003);
    check("rd1_done_k", done_k, 3);
    check("rd1_err_cnt", err_cnt, 0);

    run_cmd(OP_LDI, 4'd0, 4'd2, 16'h00A5);
    check("ldi_done_k", done_k, 4);
    check("ldi_wen_cycles", wen_cnt, 1);
    check("ldi_wen_bus", 32'(w_bus), 32'h00A5);
    check("ldi_wen_idx", 32'(w_idx), 2);
    check("ldi_no_rdv", rdv_cnt, 0);
    run_cmd(OP_RD, 4'd2, 4'd0, 16'h0);
    check("ldi_rdback", 32'(rdata), 32'h00A5);

    run_cmd(OP_NOP, 4'd0, 4'd0, 16'h0);
    check("nop_done_k", done_k, 1);
    check("nop_strobes", strobe_cnt, 0);

    do_reset();
    run_cmd(OP_MOV, 4'd0, 4'd3, 16'h0);
    check("mov_done_k", done_k, 7);
    check("mov_done_cnt", done_cnt, 1);
    check("mov_rd2_bus", 32'(bus_a[2]), 32'h0002);
    check("mov_turn_ren", 32'(ren_a[3]), 0);
    check("mov_turn_bus_z", 32'(flt_a[3]), 1);
    check("mov_wen_idx", 32'(w_idx), 3);
    check("mov_wen_cycles", wen_cnt, 1);
    check("mov_overlap", overlap, 0);
    check("mov_r3", 32'(regs[3]), 32'h0002);

    // Three LDIs with cmd_valid held; next fields appear while the previous command runs
    qd[0] = 4'd1; qi[0] = 16'h1234;
    qd[1] = 4'd2; qi[1] = 16'hBEEF;
    qd[2] = 4'd3; qi[2] = 16'h0F0F;
    @(negedge clk);
    mif.cmd_op = OP_LDI; mif.cmd_src = 4'd0;
    mif.cmd_dst = qd[0]; mif.cmd_imm = qi[0];
    mif.cmd_valid = 1'b1;
    j = 0; k = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    while (j < 3 && k < 60) begin
      @(negedge clk);
      k++;
      if (mif.cmd_ready) begin
        acc[j] = k;
        j++;
        @(posedge clk);
        #1;
        if (j < 3) begin
          mif.cmd_dst = qd[j]; mif.cmd_imm = qi[j];
        end else begin
          mif.cmd_valid = 1'b0; mif.cmd_dst = 4'd0; mif.cmd_imm = 16'hDEAD;
        end
      end
    end
    mif.cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("q_accepts", j, 3);
    check("q_gap01", acc[1] - acc[0], 5);
    check("q_gap12", acc[2] - acc[1], 5);
    check("q_r1", 32'(regs[1]), 32'h1234);
    check("q_r2", 32'(regs[2]), 32'hBEEF);
    check("q_r3", 32'(regs[3]), 32'h0F0F);
    check("q_r0_kept", 32'(regs[0]), 32'h0002);

    // Reset asserted while MOV sits in WR2
    @(negedge clk);
    mif.cmd_op = OP_MOV; mif.cmd_src = 4'd1; mif.cmd_dst = 4'd2; mif.cmd_imm = '0;
    mif.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    mif.cmd_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mif.bus_wEn && n < 20);
    check("mid_wr2_reached", 32'(mif.bus_wEn), 1);
    reset = 1'b1;
    #1;
    check("mid_wen", 32'(mif.bus_wEn), 0);
    check("mid_ren", 32'(mif.bus_rEn), 0);
    check("mid_bus_z", 32'(floated(bus)), 1);
    check("mid_ready", 32'(mif.cmd_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mif.done) n++;
    end
    check("mid_no_done", n, 0);
    run_cmd(OP_RD, 4'd0, 4'd0, 16'h0);
    check("mid_next_rd", 32'(rdata), 32'h0002);
    check("mid_next_done_k", done_k, 3);

`ifdef REG_BUS_RANGE_CHECK_EN
    run_cmd(OP_MOV, 4'd5, 4'd1, 16'h0);
    check("range_err_k", err_k, 1);
    check("range_err_cnt", err_cnt, 1);
    check("range_no_done", done_cnt, 0);
    check("range_no_strobe", strobe_cnt, 0);
    check("range_r1_kept", 32'(regs[1]), 32'h0003);
`else
    run_cmd(OP_MOV, 4'd5, 4'd1, 16'h0);
    check("range_rd1_idx", 32'(idx_a[1]), 5);
    check("range_rd1_ren", 32'(ren_a[1]), 1);
    check("range_done_k", done_k, 7);
    check("range_no_err", err_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator side of the shared register-file bus: 4-bit index, read-enable and write-enable strobes, and a 16-bit tri-state data bus.
- Accepts one command at a time from the control unit over a valid/ready handshake.
- Sequences the strobes for three operations:
  - LDI: load an immediate into a register.
  - MOV: register-to-register copy.
  - RD: read a register out to the control unit.
- Sole owner of bus drive while it is writing. Releases the bus whenever a register is driving it.

Parameters:
DATA_W, 16, bus/register data width
IDX_W, 4, register index width
NUM_REGS, 4, number of implemented registers (used only by the optional range check)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when cmd_valid&&cmd_ready at posedge clk
cmd_op  in  2  00 NOP, 01 LDI, 10 MOV, 11 RD
cmd_src  in  IDX_W  source register (MOV, RD)
cmd_dst  in  IDX_W  destination register (LDI, MOV)
cmd_imm  in  DATA_W  immediate (LDI)
rd_data  out  DATA_W  last value captured by RD, held until next RD
rd_valid  out  1  one-cycle pulse, rd_data updated
done  out  1  one-cycle pulse, command complete
err  out  1  one-cycle pulse, command rejected (optional feature only, else tied 0)
bus_index  out  IDX_W  register index
bus_rEn  out  1  register read enable; register latches index on its rising edge and drives bus while high
bus_wEn  out  1  register write enable; register captures bus on its rising edge
bus  inout  DATA_W  shared data bus

Behaviour:
- Reset (async): state IDLE; cmd_ready=1; bus_rEn=0, bus_wEn=0, bus_index=0, bus=Z; rd_data=0, data_q=0; rd_valid=done=err=0.
- Reset mid-command: strobes drop and bus releases immediately; the command is abandoned and no done is produced. The register file's own reset is not driven by this block.
- Outputs: all bus-side outputs are registered or decoded from the state register only. There is no combinational path from cmd_* to bus_*.
- cmd_ready=1 only in IDLE.
- Command capture: src, dst, imm and op are latched into internal registers on acceptance. cmd_* changes afterwards have no effect.
- States:
  - IDLE: all strobes 0, bus Z.
  - RD1: bus_index=src, bus_rEn=1.
  - RD2: bus_rEn=1, bus_index=src; data_q <= bus at end of cycle.
  - TURN: bus_rEn=0, bus Z; one dead cycle before the block drives.
  - WR1: bus driven with data_q, bus_index=dst, bus_wEn=0 (setup).
  - WR2: bus_wEn=1 (rising edge = write), bus still driven.
  - WR3: bus_wEn=0, bus still driven (hold).
  - DONE: bus Z, done=1; for RD also rd_valid=1 and rd_data=data_q.
- Sequences (T0 = accept cycle):
  - RD: RD1, RD2, DONE, IDLE. done at T3.
  - MOV: RD1, RD2, TURN, WR1, WR2, WR3, DONE. done at T7.
  - LDI: data_q<=imm at accept; WR1, WR2, WR3, DONE. done at T4.
  - NOP: DONE directly. done at T1, no strobes.
- Invariants:
  - Bus driven only in WR1..WR3.
  - bus_rEn and bus drive never both active in the same cycle.
  - bus_rEn and bus_wEn never high simultaneously.
  - bus_index stable in every cycle where bus_rEn rises or bus_wEn is high.
- MOV with src==dst: performed normally (read then rewrite same value).
- Back-to-back: a new command is accepted the cycle the block is back in IDLE (one cycle after DONE).

Optional Feature:
- Macro REG_BUS_RANGE_CHECK_EN.
- Defined: at acceptance, any used index (src for MOV/RD, dst for LDI/MOV) >= NUM_REGS sends the block to a one-cycle ERR state. ERR gives err=1, no strobes, no done, then returns to IDLE. The register file is untouched.
- Undefined: no check; the index is driven as given. err is tied 0.

Test Plan:
- Reset, then RD src=0 and RD src=1 (register model resets r0=2, r1=3). Required: rd_valid with rd_data=0x0002, then 0x0003; done exactly 3 cycles after each accept.
- LDI dst=2 imm=0x00A5, then RD src=2. Required: rd_data=0x00A5; bus_wEn high exactly one cycle with bus=0x00A5 and bus_index=2.
- MOV src=0 dst=3 after reset. Required: r3=0x0002, done at T7, TURN cycle shows bus Z with rEn=0; no cycle where bus is driven while bus_rEn=1.
- cmd_valid held high with 3 queued LDIs. Required: cmd_ready low during each command; accepts spaced 5 cycles apart; cmd_* changes mid-command ignored.
- Reset asserted during WR2 of a MOV. Required: same-cycle bus=Z, bus_wEn=0, bus_rEn=0; no done; next command runs normally.
- With REG_BUS_RANGE_CHECK_EN, MOV src=5 dst=1. Required: err pulse at T1, no strobes, r1 unchanged. Without the macro: bus_index=5 is driven during RD1.
